single_macc_decimator: RTL and testbench
========================================

SINGLE_MACC_DECIMATOR -- requirements
Module: single_macc_decimator

Interface
REQ-001 SHALL have parameter DecimationK, default 2: decimation factor, legal range 1..16.
REQ-002 SHALL have parameter TapsNum, default 16: number of FIR taps, fixed at 16 (4-bit coefficient address).
REQ-003 SHALL have port Clk_i, input, 1 bit: the only clock; all logic, including coefficient writes, runs on its rising edge.
REQ-004 SHALL have port Rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port CoeffAddr_i, input, 4 bits: coefficient write address (tap index k).
REQ-006 SHALL have port CoeffData_i, input, 18 bits: signed coefficient in Q0.17 format.
REQ-007 SHALL have port CoeffWr_i, input, 1 bit: coefficient write strobe.
REQ-008 SHALL have port Data_i, input, 18 bits: signed input sample at the high rate.
REQ-009 SHALL have port DataNd_i, input, 1 bit: one-cycle new-data strobe for Data_i.
REQ-010 SHALL have port Data_o, output, 18 bits: signed decimated output sample.
REQ-011 SHALL have port DataValid_o, output, 1 bit: one-cycle valid pulse for Data_o.
REQ-012 SHALL have port Busy_o, output, 1 bit: high while a computation is in progress.
REQ-013 SHALL have port Overrun_o, output, 1 bit: one-cycle pulse when a computation trigger is dropped.

Function
REQ-014 SHALL, when CoeffWr_i=1, write CoeffData_i to coefficient RAM[CoeffAddr_i]; reads SHALL see the new value from the next cycle.
REQ-015 SHALL, when DataNd_i=1, write Data_i into a 32-entry circular delay line at wrPtr and increment wrPtr modulo 32, in every FSM state.
REQ-016 SHALL count accepted samples in phaseCnt (0..DecimationK-1); a sample accepted with phaseCnt=DecimationK-1 SHALL be a trigger and SHALL return phaseCnt to 0.
REQ-017 SHALL, on a trigger in IDLE, capture base=wrPtr (the slot of the new sample), clear the accumulator and enter MAC.
REQ-018 SHALL, in MAC, perform one multiply-accumulate per cycle for k=0..15: acc += h[k]*x[base-k mod 32]; after 16 cycles it SHALL enter DRAIN.
REQ-019 SHALL spend 2 cycles in DRAIN to flush the multiplier pipeline, then 1 cycle in OUT, then return to IDLE.
REQ-020 SHALL form products as 36-bit signed values and accumulate in a 40-bit signed accumulator.
REQ-021 SHALL output acc[34:17], saturated to the range -131072..+131071.
REQ-022 SHALL update Data_o and assert DataValid_o for exactly one cycle, 19 cycles after the clock edge that sampled the trigger.
REQ-023 SHALL hold Data_o stable between valid pulses.
REQ-024 SHALL assert Busy_o in the MAC, DRAIN and OUT states.
REQ-025 SHALL, on a trigger outside IDLE, still store the sample and reset phaseCnt, skip the computation, and pulse Overrun_o for one cycle.
REQ-026 SHALL guarantee that samples written during a computation never overwrite the 16 slots being read (32-deep ring).
REQ-027 SHALL, with DecimationK=1, treat every accepted sample as a trigger.

Reset
REQ-028 SHALL, with Rst_i=1 at a clock edge, set the FSM to IDLE, and wrPtr, phaseCnt, the accumulator and all 32 delay-line entries to 0.
REQ-029 SHALL, on reset, set Data_o=0, DataValid_o=0, Busy_o=0 and Overrun_o=0.
REQ-030 SHALL leave coefficient RAM unaffected by reset; coefficients SHALL persist across reset.
REQ-031 SHALL, on reset asserted mid-computation, abort the computation with no DataValid_o pulse; DataNd_i and CoeffWr_i SHALL be ignored while Rst_i=1.

Configuration
REQ-032 SHALL, with macro SINGLE_MACC_DECIMATOR_ROUND_EN defined, add 2^16 to the accumulator before the shift and saturation (round half up).
REQ-033 SHALL, without SINGLE_MACC_DECIMATOR_ROUND_EN, truncate toward minus infinity.

Verification
REQ-034 Impulse, DecimationK=2, h[k]=4096*(k+1), first sample after reset 65536, then zeros, DataNd_i every 16 cycles -> outputs 4096, 8192, ..., 32768 (8 values, 2048*(2k+2)), then 0.
REQ-035 Constant input 1000, h[0]=65536, all other h=0, DecimationK=4 -> Data_o=500 on every 4th sample, 19 cycles after each trigger.
REQ-036 All h=131071: input constant 131071 -> Data_o=131071; input constant -131072 -> Data_o=-131072 (saturation).
REQ-037 h[0]=1, x=65536 -> Data_o=0 without the macro and 1 with SINGLE_MACC_DECIMATOR_ROUND_EN.
REQ-038 DecimationK=2, DataNd_i held high continuously -> one valid pulse per 20 cycles, Overrun_o pulse on each dropped trigger, Busy_o matches MAC/DRAIN/OUT.
REQ-039 Rst_i pulsed 5 cycles into MAC -> no DataValid_o pulse, all outputs 0; coefficients still intact on the next run.

Source files
------------

// File: rtl/single_macc_decimator.sv
// -----------------------------------------------------------------------------
// single_macc_decimator
//
// Decimating 16-tap FIR filter built around one multiply-accumulate unit.
// Every DecimationK-th accepted input sample triggers a computation. The
// computation runs 16 MAC cycles over a 32-deep circular delay line, then
// 2 drain cycles for the multiplier pipeline, then 1 output cycle. A trigger
// that arrives while a computation is running is dropped and flagged. Samples
// are always stored, even while a computation is running.
//
// Parameters
//   DecimationK  decimation factor, 1..16
//   TapsNum      number of taps, fixed at 16
//
// Ports
//   Clk_i        clock, rising edge
//   Rst_i        synchronous active-high reset (coefficient RAM is kept)
//   CoeffAddr_i  coefficient write address (tap index)
//   CoeffData_i  signed Q0.17 coefficient
//   CoeffWr_i    coefficient write strobe
//   Data_i       signed input sample
//   DataNd_i     new-data strobe for Data_i
//   Data_o       signed decimated output, held between valid pulses
//   DataValid_o  one-cycle valid pulse for Data_o
//   Busy_o       high in the MAC, DRAIN and OUT states
//   Overrun_o    one-cycle pulse when a trigger is dropped
//
// Build option
//   SINGLE_MACC_DECIMATOR_ROUND_EN  round half up before the output shift;
//                                   otherwise truncate toward minus infinity.
// -----------------------------------------------------------------------------
module single_macc_decimator #(
  parameter int DecimationK = 2,
  parameter int TapsNum     = 16
) (
  input  logic        Clk_i,
  input  logic        Rst_i,
  input  logic [3:0]  CoeffAddr_i,
  input  logic [17:0] CoeffData_i,
  input  logic        CoeffWr_i,
  input  logic [17:0] Data_i,
  input  logic        DataNd_i,
  output logic [17:0] Data_o,
  output logic        DataValid_o,
  output logic        Busy_o,
  output logic        Overrun_o
);

  localparam int DATA_W = 18;
  localparam int COEF_W = 18;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = 40;
  localparam int DEPTH  = 32;

  localparam logic [3:0] PHASE_LAST = 4'(DecimationK - 1);
  localparam logic [3:0] TAP_LAST   = 4'(TapsNum - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd131071;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd131072;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_OUT} state_t;

  // Scale the accumulator back to Q0.17 (optionally rounding) and clamp.
  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    r = acc;
`ifdef SINGLE_MACC_DECIMATOR_ROUND_EN
    r = r + 40'sd65536;
`endif
    r = r >>> 17;
    if (r > SAT_MAX) begin
      r = SAT_MAX;
    end else if (r < SAT_MIN) begin
      r = SAT_MIN;
    end
    return r[DATA_W-1:0];
  endfunction

  // Storage
  logic signed [COEF_W-1:0] coef_q [TapsNum];
  logic signed [DATA_W-1:0] dly_q  [DEPTH];

  // Control state
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  base_q, base_d;
  logic [4:0]  wr_ptr_q, wr_ptr_d;
  logic [3:0]  phase_q, phase_d;

  // Datapath state
  logic signed [DATA_W-1:0] x_p0_q, x_p0_d;
  logic signed [COEF_W-1:0] h_p0_q, h_p0_d;
  logic                     vld_p0_q, vld_p0_d;
  logic signed [PROD_W-1:0] prod_p1_q, prod_p1_d;
  logic                     vld_p1_q, vld_p1_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  // Outputs
  logic signed [DATA_W-1:0] data_o_q, data_o_d;
  logic                     valid_q, valid_d;
  logic                     overrun_q, overrun_d;

  logic       trigger;
  logic [4:0] rd_idx;

  // State register and all resettable flops
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      wr_ptr_q  <= '0;
      phase_q   <= '0;
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      acc_q     <= '0;
      data_o_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      wr_ptr_q  <= wr_ptr_d;
      phase_q   <= phase_d;
      vld_p0_q  <= vld_p0_d;
      vld_p1_q  <= vld_p1_d;
      acc_q     <= acc_d;
      data_o_q  <= data_o_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      if (DataNd_i) begin
        dly_q[wr_ptr_q] <= Data_i;
      end
    end
  end

  // Coefficient RAM survives reset; writes are only blocked while it is held.
  always_ff @(posedge Clk_i) begin
    if (!Rst_i && CoeffWr_i) begin
      coef_q[CoeffAddr_i] <= CoeffData_i;
    end
  end

  // Pipeline data registers carry no reset; their valid bits qualify them.
  always_ff @(posedge Clk_i) begin
    x_p0_q    <= x_p0_d;
    h_p0_q    <= h_p0_d;
    prod_p1_q <= prod_p1_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_MAC;
          cnt_d   = '0;
        end
      end
      S_MAC: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == TAP_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_OUT;
          cnt_d   = '0;
        end
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sample intake and MAC datapath
  always_comb begin
    trigger  = DataNd_i && (phase_q == PHASE_LAST);
    wr_ptr_d = DataNd_i ? wr_ptr_q + 5'd1 : wr_ptr_q;
    phase_d  = phase_q;
    if (DataNd_i) begin
      phase_d = trigger ? 4'd0 : phase_q + 4'd1;
    end
    // The triggering sample lands at wr_ptr on this edge, so it is tap 0.
    base_d = (state_q == S_IDLE && trigger) ? wr_ptr_q : base_q;
    // Writes during a run only move forward from base, so they stay clear of
    // the 16 slots behind it until all of them have been read.
    rd_idx = base_q - {1'b0, cnt_q};

    // stage p0: operand fetch
    x_p0_d   = dly_q[rd_idx];
    h_p0_d   = coef_q[cnt_q];
    vld_p0_d = (state_q == S_MAC);

    // stage p1: multiply
    prod_p1_d = x_p0_q * h_p0_q;
    vld_p1_d  = vld_p0_q;

    // stage p2: accumulate
    acc_d = acc_q;
    if (state_q == S_IDLE && trigger) begin
      acc_d = '0;
    end else if (vld_p1_q) begin
      acc_d = acc_q + $signed({{(ACC_W-PROD_W){prod_p1_q[PROD_W-1]}}, prod_p1_q});
    end
  end

  // Output logic
  always_comb begin
    Busy_o    = (state_q != S_IDLE);
    data_o_d  = (state_q == S_OUT) ? round_sat(acc_q) : data_o_q;
    valid_d   = (state_q == S_OUT);
    overrun_d = trigger && (state_q != S_IDLE);
  end

  assign Data_o      = data_o_q;
  assign DataValid_o = valid_q;
  assign Overrun_o   = overrun_q;

endmodule

// File: tb/tb_single_macc_decimator.sv
module tb_single_macc_decimator;

  localparam int TB_K = 2;

  logic               Clk_i;
  logic               Rst_i;
  logic [3:0]         CoeffAddr_i;
  logic [17:0]        CoeffData_i;
  logic               CoeffWr_i;
  logic [17:0]        Data_i;
  logic               DataNd_i;
  logic signed [17:0] Data_o;
  logic               DataValid_o;
  logic               Busy_o;
  logic               Overrun_o;

  single_macc_decimator #(.DecimationK(TB_K), .TapsNum(16)) dut (
    .Clk_i      (Clk_i),
    .Rst_i      (Rst_i),
    .CoeffAddr_i(CoeffAddr_i),
    .CoeffData_i(CoeffData_i),
    .CoeffWr_i  (CoeffWr_i),
    .Data_i     (Data_i),
    .DataNd_i   (DataNd_i),
    .Data_o     (Data_o),
    .DataValid_o(DataValid_o),
    .Busy_o     (Busy_o),
    .Overrun_o  (Overrun_o)
  );

  initial Clk_i = 1'b0;
  always #5 Clk_i = ~Clk_i;

  int edge_n = 0;
  always @(posedge Clk_i) edge_n <= edge_n + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, n, act, exp);
    end
  endtask

  // Reference model: full sample history, coefficient table, phase count,
  // edge of the last accepted trigger.
  typedef struct { int e; int y; } exp_t;
  exp_t sbq[$];
  int   hist[$];
  int   h_m[16];
  int   phase_m  = 0;
  int   last_acc = -1000;
  int   exp_dout = 0;
  bit   ovr_exp[int];
  int   got_q[$];

  function automatic int model_y();
    longint s;
    longint r;
    s = 0;
    for (int k = 0; k < 16; k++) begin
      longint xv;
      xv = (k < hist.size()) ? longint'(hist[hist.size()-1-k]) : 0;
      s += longint'(h_m[k]) * xv;
    end
`ifdef SINGLE_MACC_DECIMATOR_ROUND_EN
    s += 65536;
`endif
    r = s >>> 17;
    if (r > 131071) r = 131071;
    if (r < -131072) r = -131072;
    return int'(r);
  endfunction

  function automatic int rnd18();
    logic signed [17:0] v;
    v = 18'($urandom);
    return int'(v);
  endfunction

  // Drive one cycle of inputs and advance the model for the upcoming edge.
  task automatic drive(input bit rst, input bit nd, input int d,
                       input bit cw, input int ca, input int cd);
    int  e;
    bit  trig;
    @(negedge Clk_i);
    #1;
    Rst_i       = rst;
    DataNd_i    = nd;
    Data_i      = 18'(d);
    CoeffWr_i   = cw;
    CoeffAddr_i = 4'(ca);
    CoeffData_i = 18'(cd);
    e = edge_n + 1;
    if (rst) begin
      hist.delete();
      phase_m  = 0;
      last_acc = -1000;
      sbq.delete();
      exp_dout = 0;
    end else begin
      if (cw) h_m[ca] = cd;
      if (nd) begin
        hist.push_back(d);
        if (hist.size() > 64) void'(hist.pop_front());
        trig    = (phase_m == TB_K - 1);
        phase_m = trig ? 0 : phase_m + 1;
        if (trig) begin
          if (e - last_acc >= 20) begin
            last_acc = e;
            sbq.push_back('{e, model_y()});
          end else begin
            ovr_exp[e] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic sample(input int d);
    drive(0, 1, d, 0, 0, 0);
  endtask

  // Monitor: compares every cycle against the model's expectations.
  int n_m;
  bit ev_m;
  bit eb_m;
  always @(negedge Clk_i) begin
    n_m  = edge_n;
    ev_m = (sbq.size() > 0) && (sbq[0].e + 19 == n_m);
    chk("valid", n_m, int'(DataValid_o), int'(ev_m));
    if (ev_m) begin
      exp_dout = sbq[0].y;
      void'(sbq.pop_front());
    end
    if (DataValid_o === 1'b1) got_q.push_back(int'(Data_o));
    chk("dout", n_m, int'(Data_o), exp_dout);
    eb_m = (n_m >= last_acc) && (n_m <= last_acc + 18);
    chk("busy", n_m, int'(Busy_o), int'(eb_m));
    chk("overrun", n_m, int'(Overrun_o), int'(ovr_exp.exists(n_m)));
  end

  initial begin
    Rst_i = 1'b1; DataNd_i = 1'b0; Data_i = '0;
    CoeffWr_i = 1'b0; CoeffAddr_i = '0; CoeffData_i = '0;
    repeat (3) drive(1, 0, 0, 0, 0, 0);
    idle(2);
    chk("rst_dout", edge_n, int'(Data_o), 0);
    chk("rst_busy", edge_n, int'(Busy_o), 0);

    // Impulse response: h[k] = 4096*(k+1), one sample every 16 cycles.
    for (int k = 0; k < 16; k++) drive(0, 0, 0, 1, k, 4096 * (k + 1));
    drive(1, 0, 0, 0, 0, 0);
    got_q.delete();
    for (int i = 0; i < 20; i++) begin
      sample(i == 0 ? 65536 : 0);
      idle(15);
    end
    idle(25);
    chk("imp_count", edge_n, got_q.size(), 10);
    for (int j = 0; j < 10; j++) begin
      if (j < got_q.size()) chk("imp_val", j, got_q[j], (j < 8) ? 2048 * (2 * j + 2) : 0);
    end

    // Random coefficients and data with random spacing, then a solid burst.
    for (int k = 0; k < 16; k++) drive(0, 0, 0, 1, k, rnd18());
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) sample(rnd18());
      else idle(1);
    end
    for (int i = 0; i < 60; i++) sample(rnd18());
    idle(30);

    // Saturation at both rails.
    for (int k = 0; k < 16; k++) drive(0, 0, 0, 1, k, 131071);
    for (int i = 0; i < 40; i++) sample(131071);
    idle(30);
    chk("sat_pos", edge_n, got_q[$], 131071);
    for (int i = 0; i < 40; i++) sample(-131072);
    idle(30);
    chk("sat_neg", edge_n, got_q[$], -131072);

    // Rounding of an exact half LSB.
    for (int k = 0; k < 16; k++) drive(0, 0, 0, 1, k, (k == 0) ? 1 : 0);
    for (int i = 0; i < 20; i++) sample(65536);
    idle(30);
`ifdef SINGLE_MACC_DECIMATOR_ROUND_EN
    chk("round", edge_n, got_q[$], 1);
`else
    chk("round", edge_n, got_q[$], 0);
`endif

    // Reset five cycles into MAC aborts the run; coefficients survive.
    for (int k = 0; k < 16; k++) drive(0, 0, 0, 1, k, (k == 0) ? 65536 : 0);
    drive(1, 0, 0, 0, 0, 0);
    got_q.delete();
    sample(1000);
    sample(1000);
    idle(5);
    chk("mid_busy", edge_n, int'(Busy_o), 1);
    drive(1, 0, 0, 0, 0, 0);
    idle(30);
    chk("abort_novalid", edge_n, got_q.size(), 0);
    chk("abort_dout", edge_n, int'(Data_o), 0);
    for (int i = 0; i < 4; i++) begin
      sample(1000);
      idle(21);
    end
    idle(10);
    chk("persist_count", edge_n, got_q.size(), 2);
    if (got_q.size() > 0) chk("persist_val", edge_n, got_q[$], 500);

    chk("sb_empty", edge_n, sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
